bcd_display_ctrl: RTL and testbench

- Sequencing controller for the board's seven-segment decoder bank.
- Accepts a binary value (mine count, timer, score) over a start/busy/done handshake.
- Converts it to BCD digits with a multi-cycle shift-add-3 (double-dabble) engine and holds them in a registered output bank.
- Each 4-bit digit field feeds one downstream seven-segment decoder instance, which only decodes values 0-9.

---
 rtl/bcd_display_ctrl.sv | 119 +++++++++++
 tb/tb_bcd_display_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD sequencing controller for the seven-segment decoder bank (double-dabble, one bit per cycle).
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module bcd_display_ctrl #(
  parameter int IN_W = 8,
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_W-1:0]     value,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     blank,
  output logic                ovf
);

  // Handshake: start is sampled only in IDLE. busy is high from the accepting
  // edge until the edge that leaves DONE. done pulses for one cycle, and
  // digits/blank/ovf are valid from that cycle until the next done.

  localparam int SW = 4*NDIG + 4;
  localparam int CW = $clog2(IN_W + 1);
  localparam int unsigned LIMIT = 10**NDIG;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  logic [IN_W-1:0]     shreg;
  logic [SW-1:0]       scratch;
  logic [CW-1:0]       cnt;
  logic                ovf_flag;

  logic [SW-1:0]       adj;
  logic [SW-1:0]       scratch_nxt;
  logic [IN_W-1:0]     shreg_nxt;
  logic [4*NDIG-1:0]   digits_nxt;

  // One double-dabble step: correct nibbles >= 5, then shift the pair left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < NDIG + 1; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
    digits_nxt = ovf_flag ? {NDIG{4'd9}} : scratch_nxt[4*NDIG-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      digits   <= '0;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg    <= value;
            scratch  <= '0;
            cnt      <= CW'(IN_W);
            ovf_flag <= (32'(value) >= LIMIT);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_nxt;
          shreg   <= shreg_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            digits <= digits_nxt;
            ovf    <= ovf_flag;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] blank_nxt;
  logic            upper_zero;

  // Blank digit i when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    blank_nxt  = '0;
    upper_zero = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      upper_zero   = upper_zero && (digits_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = upper_zero && !ovf_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank <= '0;
    else if (state == CONV && cnt == CW'(1))
      blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: default instance (IN_W=8, NDIG=3) and an NDIG=2 instance.
module tb_bcd_display_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  value1 = '0, value2 = '0;
  logic        busy1, done1, ovf1;
  logic [11:0] digits1;
  logic [2:0]  blank1;
  logic        busy2, done2, ovf2;
  logic [7:0]  digits2;
  logic [1:0]  blank2;

  bcd_display_ctrl #(.IN_W(8), .NDIG(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .value(value1),
    .busy(busy1), .done(done1), .digits(digits1), .blank(blank1), .ovf(ovf1)
  );

  bcd_display_ctrl #(.IN_W(8), .NDIG(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .value(value2),
    .busy(busy2), .done(done2), .digits(digits2), .blank(blank2), .ovf(ovf2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt1 = 0;

  always @(posedge clk) begin
    cyc++;
    if (done1) done_cnt1++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [19:0] m_digits(input int v, input int nd);
    logic [19:0] r = '0;
    for (int i = 0; i < nd; i++)
      r[4*i +: 4] = (v >= p10(nd)) ? 4'd9 : 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic m_ovf(input int v, input int nd);
    return v >= p10(nd);
  endfunction

  function automatic logic [4:0] m_blank(input int v, input int nd);
    logic [4:0] r = '0;
    if (BLANK_ON && v < p10(nd))
      for (int i = 1; i < nd; i++) r[i] = (v < p10(i));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_conv(input bit sel, input int v,
                         output logic [19:0] d, output logic o, output logic [4:0] b);
    int k;
    @(negedge clk);
    k = 0;
    while ((sel ? busy2 : busy1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sel) begin value2 = v[7:0]; start2 = 1'b1; end
    else     begin value1 = v[7:0]; start1 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    k = 0;
    while (!(sel ? done2 : done1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 8);
    d = sel ? {12'h0, digits2} : {8'h0, digits1};
    o = sel ? ovf2 : ovf1;
    b = sel ? {3'b0, blank2} : {2'b0, blank1};
    @(negedge clk);
    check("done_one_cycle", sel ? done2 : done1, 1'b0);
  endtask

  typedef struct {
    int          v;
    logic [11:0] d;
    logic        o;
    logic [2:0]  b;
  } vec_t;

  vec_t        tbl[8];
  logic [19:0] rd, rd2;
  logic        ro;
  logic [4:0]  rb, rb2;
  int          t1, t2, base;
  logic        ok;

  initial begin
    // blank column holds the values with leading-zero blanking enabled
    tbl[0] = '{42,  12'h042, 1'b0, 3'b100};
    tbl[1] = '{255, 12'h255, 1'b0, 3'b000};
    tbl[2] = '{0,   12'h000, 1'b0, 3'b110};
    tbl[3] = '{9,   12'h009, 1'b0, 3'b110};
    tbl[4] = '{7,   12'h007, 1'b0, 3'b110};
    tbl[5] = '{100, 12'h100, 1'b0, 3'b000};
    tbl[6] = '{10,  12'h010, 1'b0, 3'b100};
    tbl[7] = '{199, 12'h199, 1'b0, 3'b000};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   busy1,   1'b0);
    check("rst_done",   done1,   1'b0);
    check("rst_ovf",    ovf1,    1'b0);
    check("rst_digits", digits1, 12'h000);
    check("rst_blank",  blank1,  3'b000);
    check("rst_digits2", digits2, 8'h00);
    rst_n = 1'b1;

    // table-driven vectors on the default instance
    for (int i = 0; i < 8; i++) begin
      do_conv(1'b0, tbl[i].v, rd, ro, rb);
      check($sformatf("tbl_digits_%0d", tbl[i].v), rd, {8'h0, tbl[i].d});
      check($sformatf("tbl_ovf_%0d", tbl[i].v), ro, tbl[i].o);
      check($sformatf("tbl_blank_%0d", tbl[i].v), rb, BLANK_ON ? {2'b0, tbl[i].b} : 5'b0);
    end

    // back-to-back with start held high: 255 then 0
    @(negedge clk);
    start1 = 1'b1;
    value1 = 8'd255;
    @(negedge clk);
    value1 = 8'd0;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 60 && t2 < 0; k++) begin
      if (done1) begin
        if (t1 < 0) begin t1 = cyc; rd = {8'h0, digits1}; end
        else begin t2 = cyc; rd2 = {8'h0, digits1}; rb2 = {2'b0, blank1}; end
      end
      if (t2 < 0) @(negedge clk);
    end
    start1 = 1'b0;
    check("b2b_spacing", t2 - t1, 10);
    check("b2b_first",   rd,  20'h00255);
    check("b2b_second",  rd2, 20'h00000);
    check("b2b_blank",   rb2, BLANK_ON ? 5'b00110 : 5'b0);

    // start while busy is ignored
    repeat (3) @(negedge clk);
    base = done_cnt1;
    start1 = 1'b1;
    value1 = 8'd7;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    value1 = 8'd99;
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_ignore_done_count", done_cnt1 - base, 1);
    check("busy_ignore_digits", digits1, 12'h007);

    // reset in the middle of a conversion
    do_conv(1'b0, 42, rd, ro, rb);
    start1 = 1'b1;
    value1 = 8'd200;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    base = done_cnt1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   busy1,   1'b0);
    check("midrst_done",   done1,   1'b0);
    check("midrst_digits", digits1, 12'h000);
    check("midrst_ovf",    ovf1,    1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt1 - base, 0);
    check("midrst_hold",    digits1, 12'h000);

    // NDIG=2 overflow saturation then recovery
    do_conv(1'b1, 100, rd, ro, rb);
    check("n2_ovf_digits", rd, 20'h00099);
    check("n2_ovf_flag",   ro, 1'b1);
    check("n2_ovf_blank",  rb, 5'b0);
    do_conv(1'b1, 5, rd, ro, rb);
    check("n2_5_digits", rd, 20'h00005);
    check("n2_5_ovf",    ro, 1'b0);
    check("n2_5_blank",  rb, BLANK_ON ? 5'b00010 : 5'b0);

    // exhaustive sweep on the default instance
    for (int v = 0; v < 256; v++) begin
      do_conv(1'b0, v, rd, ro, rb);
      check($sformatf("sweep_digits_%0d", v), rd, m_digits(v, 3));
      check($sformatf("sweep_ovf_%0d", v),    ro, m_ovf(v, 3));
      check($sformatf("sweep_blank_%0d", v),  rb, m_blank(v, 3));
      ok = 1'b1;
      for (int i = 0; i < 3; i++) if (rd[4*i +: 4] > 4'd9) ok = 1'b0;
      check($sformatf("sweep_range_%0d", v), ok, 1'b1);
    end

    // random values on the NDIG=2 instance
    for (int n = 0; n < 40; n++) begin
      int v;
      v = $urandom_range(0, 255);
      do_conv(1'b1, v, rd, ro, rb);
      check($sformatf("rand_digits_%0d", v), rd, m_digits(v, 2));
      check($sformatf("rand_ovf_%0d", v),    ro, m_ovf(v, 2));
      check($sformatf("rand_blank_%0d", v),  rb, m_blank(v, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
